// File: rtl/sequenciador_fases.sv
// Phase sequencer: runs a modulo-MOD phase counter for a programmed number of laps,
// with pause/abort control, one-hot phase decode, wrap and done pulses.
module sequenciador_fases #(
   parameter int unsigned MOD = 5,
   parameter int unsigned PW  = 3,
   parameter int unsigned LW  = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          pause,
   input  logic          abort,
   input  logic [LW-1:0] laps,
   output logic [PW-1:0] phase,
   output logic [MOD-1:0] phase_oh,
   output logic [LW-1:0] lap_cnt,
   output logic          busy,
   output logic          wrap,
   output logic          done
);

   localparam logic [PW-1:0] PH_LAST = PW'(MOD - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    phase_q, phase_d;
   logic [MOD-1:0]   phase_oh_q, phase_oh_d;
   logic [LW-1:0]    lap_q, lap_d;
   logic [LW-1:0]    laps_r_q, laps_r_d;
   logic             busy_q, busy_d;
   logic             wrap_q, wrap_d;
   logic             done_q, done_d;
   logic [LW-1:0]    lap_inc;
   logic             adv;

   // Next-state and registered-output logic
   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      lap_d      = lap_q;
      laps_r_d   = laps_r_q;
      busy_d     = busy_q;
      wrap_d     = 1'b0;
      done_d     = 1'b0;
      adv        = 1'b0;
      lap_inc    = lap_q + LW'(1);
      phase_oh_d = '0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               if (laps != '0) begin
                  laps_r_d = laps;
                  lap_d    = '0;
                  phase_d  = '0;
                  busy_d   = 1'b1;
                  state_d  = S_RUN;
               end else begin
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
         S_RUN: begin
            if (abort) begin
               state_d = S_IDLE;
               phase_d = '0;
               lap_d   = '0;
               busy_d  = 1'b0;
            end else if (pause) begin
               state_d = S_PAUSE;
            end else begin
               adv = 1'b1;
            end
         end
         S_PAUSE: begin
            if (abort) begin
               state_d = S_IDLE;
               phase_d = '0;
               lap_d   = '0;
               busy_d  = 1'b0;
            end else if (!pause) begin
               state_d = S_RUN;
               adv     = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            phase_d = '0;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            phase_d = '0;
            busy_d  = 1'b0;
         end
      endcase

      // Phase advance; the final wrap completes the run in the same edge
      if (adv) begin
         if (phase_q != PH_LAST) begin
            phase_d = phase_q + PW'(1);
         end else begin
            phase_d = '0;
            lap_d   = lap_inc;
            wrap_d  = 1'b1;
            if (lap_inc == laps_r_q) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
      end

      if (busy_d) begin
         phase_oh_d = MOD'(1) << phase_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         phase_q    <= '0;
         phase_oh_q <= '0;
         lap_q      <= '0;
         laps_r_q   <= '0;
         busy_q     <= 1'b0;
         wrap_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         phase_oh_q <= phase_oh_d;
         lap_q      <= lap_d;
         laps_r_q   <= laps_r_d;
         busy_q     <= busy_d;
         wrap_q     <= wrap_d;
         done_q     <= done_d;
      end
   end

   assign phase    = phase_q;
   assign phase_oh = phase_oh_q;
   assign lap_cnt  = lap_q;
   assign busy     = busy_q;
   assign wrap     = wrap_q;
   assign done     = done_q;

endmodule

// File: tb/tb_sequenciador_fases.sv
// Bench for sequenciador_fases: directed scenarios then random traffic, all
// checked against a position-based reference model.
module tb_sequenciador_fases;

   localparam int unsigned MOD = 5;
   localparam int unsigned PW  = 3;
   localparam int unsigned LW  = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          pause;
   logic          abort;
   logic [LW-1:0] laps;
   logic [PW-1:0] phase;
   logic [MOD-1:0] phase_oh;
   logic [LW-1:0] lap_cnt;
   logic          busy;
   logic          wrap;
   logic          done;

   int checks = 0;
   int errors = 0;

   // Reference model: progress is a single position pos = lap*MOD + phase
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
   int m_mode;
   int m_pos;
   int m_laps;
   int m_wrap;
   int m_done;

   sequenciador_fases #(.MOD(MOD), .PW(PW), .LW(LW)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .pause    (pause),
      .abort    (abort),
      .laps     (laps),
      .phase    (phase),
      .phase_oh (phase_oh),
      .lap_cnt  (lap_cnt),
      .busy     (busy),
      .wrap     (wrap),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s @%0t observed=%0d expected=%0d", tag, $time, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_mode = M_IDLE;
      m_pos  = 0;
      m_laps = 0;
      m_wrap = 0;
      m_done = 0;
   endfunction

   function automatic void model_advance();
      m_pos++;
      if (m_pos % MOD == 0) m_wrap = 1;
      if (m_pos == m_laps * MOD) begin
         m_mode = M_DONE;
         m_done = 1;
      end
   endfunction

   function automatic void model_edge(input int st, input int pa, input int ab, input int lp);
      m_wrap = 0;
      m_done = 0;
      case (m_mode)
         M_IDLE: if (st != 0) begin
            if (lp != 0) begin
               m_laps = lp;
               m_pos  = 0;
               m_mode = M_RUN;
            end else begin
               m_mode = M_DONE;
               m_done = 1;
            end
         end
         M_RUN: begin
            if (ab != 0) begin m_mode = M_IDLE; m_pos = 0; end
            else if (pa != 0) m_mode = M_PAUSE;
            else model_advance();
         end
         M_PAUSE: begin
            if (ab != 0) begin m_mode = M_IDLE; m_pos = 0; end
            else if (pa == 0) begin m_mode = M_RUN; model_advance(); end
         end
         default: m_mode = M_IDLE;
      endcase
   endfunction

   task automatic check_all(input string ctx);
      int busy_e;
      int ph_e;
      busy_e = (m_mode == M_RUN || m_mode == M_PAUSE) ? 1 : 0;
      ph_e   = m_pos % MOD;
      chk({ctx, ".phase"},    int'(phase),    ph_e);
      chk({ctx, ".phase_oh"}, int'(phase_oh), busy_e != 0 ? (1 << ph_e) : 0);
      chk({ctx, ".lap_cnt"},  int'(lap_cnt),  m_pos / MOD);
      chk({ctx, ".busy"},     int'(busy),     busy_e);
      chk({ctx, ".wrap"},     int'(wrap),     m_wrap);
      chk({ctx, ".done"},     int'(done),     m_done);
   endtask

   // One clock: model sees the inputs held across the rising edge
   task automatic step(input string ctx);
      @(posedge clk);
      model_edge(int'(start), int'(pause), int'(abort), int'(laps));
      @(negedge clk);
      check_all(ctx);
   endtask

   task automatic drive(input logic st, input logic pa, input logic ab, input int lp);
      start = st;
      pause = pa;
      abort = ab;
      laps  = LW'(lp);
   endtask

   task automatic mid_cycle_reset(input string ctx);
      rst = 1'b0;
      #1;
      model_reset();
      check_all(ctx);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      int n;
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 0);
      model_reset();
      repeat (2) @(negedge clk);
      check_all("reset");
      rst = 1'b1;
      step("idle");

      // Normal run, laps=2; start/laps noise while busy must not disturb it
      drive(1'b1, 1'b0, 1'b0, 2);
      step("norm_start");
      n = 0;
      while (done !== 1'b1 && n < 40) begin
         if (n == 3) drive(1'b1, 1'b0, 1'b0, 7);
         else        drive(1'b0, 1'b0, 1'b0, 7);
         step("norm");
         n++;
      end
      chk("norm_latency", n, 10);
      chk("norm_lapcnt", int'(lap_cnt), 2);
      drive(1'b0, 1'b0, 1'b0, 0);
      step("norm_tail");

      // Zero laps: done right after the start edge, never busy
      drive(1'b1, 1'b0, 1'b0, 0);
      step("zero_start");
      chk("zero_done", int'(done), 1);
      chk("zero_busy", int'(busy), 0);
      drive(1'b0, 1'b0, 1'b0, 0);
      step("zero_tail");
      chk("zero_done_drop", int'(done), 0);

      // Pause for three edges at phase 2 of a single lap
      drive(1'b1, 1'b0, 1'b0, 1);
      step("pause_start");
      n = 0;
      while (done !== 1'b1 && n < 40) begin
         drive(1'b0, (n >= 2 && n < 5) ? 1'b1 : 1'b0, 1'b0, 1);
         step("pause");
         if (n == 4) chk("pause_hold", int'(phase), 2);
         n++;
      end
      chk("pause_latency", n, 8);
      drive(1'b0, 1'b0, 1'b0, 0);
      step("pause_tail");

      // Abort at phase 3, lap 0
      drive(1'b1, 1'b0, 1'b0, 2);
      step("abort_start");
      drive(1'b0, 1'b0, 1'b0, 2);
      repeat (3) step("abort_run");
      chk("abort_at3", int'(phase), 3);
      drive(1'b0, 1'b0, 1'b1, 2);
      step("abort");
      chk("abort_busy", int'(busy), 0);
      drive(1'b0, 1'b0, 1'b0, 2);
      repeat (12) step("abort_after");

      // Asynchronous reset while at phase 4
      drive(1'b1, 1'b0, 1'b0, 1);
      step("rst_start");
      drive(1'b0, 1'b0, 1'b0, 1);
      repeat (4) step("rst_run");
      chk("rst_at4", int'(phase), 4);
      mid_cycle_reset("rst_mid");
      step("rst_after");
      drive(1'b1, 1'b0, 1'b0, 1);
      step("rst_restart");
      drive(1'b0, 1'b0, 1'b0, 1);
      repeat (6) step("rst_rerun");

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
               ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
               ($urandom_range(0, 47) == 0) ? 1'b1 : 1'b0,
               int'($urandom_range(0, 3)));
         if ($urandom_range(0, 299) == 0) mid_cycle_reset("rnd_rst");
         step("rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
